trace_stim_gen: RTL and testbench
=================================

# trace_stim_gen

Deterministic pseudo-random stimulus source for the synthetic spec-mining designs. Drives the paired 2-bit input channels of the spec-instance wrapper (`a_i_0`/`a_i_1` per instance) with per-channel random values held for random durations. It also emits a `valid` strobe marking cycles that belong to the recorded trace. Runs are bounded, restartable and reproducible from a fixed seed, so mined traces regenerate bit-exactly.

## Interface
Parameters:
- `N_CH`, 10, number of 2-bit channels, 1..16.
- `SEED`, 32'hACE1_2024, LFSR seed; a value of 0 is replaced by 1.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  abort the run; sampled only in RUN.
- `num_cycles`  in  32  trace length in samples; latched on `start`.
- `hold_max`  in  4  maximum extra hold cycles per value; latched on `start`.
- `a_out`  out  2*N_CH  channel i is `a_out[2i+1:2i]`; bit 2i maps to `a_{i+1}_0` and bit 2i+1 to `a_{i+1}_1`.
- `valid`  out  1  current `a_out` is a trace sample.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at the end of a run.
- `cycle_cnt`  out  32  number of samples emitted in the current or last run.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset puts it in IDLE.
- Reset values: all outputs 0, LFSR = SEED, all hold counters 0.
- LFSR: 32-bit Galois, right shift, polynomial x^32+x^22+x^2+x+1. Step: `l' = (l>>1) ^ (l[0] ? 32'h8020_0003 : 0)`.
- Helper functions of LFSR word `l`:
  - `val_i(l) = {l[(2i+1)%32], l[2i%32]}`.
  - `r_i(l) = l[(2i+23)%32 : (2i+20)%32]`, a 4-bit window taken modulo 32.
  - `reload_i(l) = min(r_i(l), hold_max)`.
- IDLE, `start`=1:
  - If `num_cycles`==0: go to DONE. No samples are emitted.
  - Otherwise: latch `num_cycles` and `hold_max`, clear `cycle_cnt`, set each channel value = `val_i(SEED)` and counter = `reload_i(SEED)`, set LFSR = step(SEED), go to RUN.
- RUN, every cycle:
  - `valid`=1, `busy`=1, `cycle_cnt`++.
  - LFSR steps once.
  - Per channel, using the current LFSR word `l`: if counter==0, load value `val_i(l)` and counter `reload_i(l)`; otherwise decrement the counter and hold the value.
  - Net effect: each value persists for `reload`+1 samples.
- Leaving RUN: RUN → DONE after the cycle in which `cycle_cnt` equals latched `num_cycles`-1, or after any RUN cycle with `stop`=1. The sample in the stop cycle is still valid.
- DONE: `done`=1, `valid`=0, `a_out`=0, `busy`=0. Lasts one cycle, then IDLE unconditionally.
- Ignored inputs: `start` in RUN and DONE; `stop` outside RUN. Simultaneous `start`+`stop` in IDLE means start.
- `cycle_cnt` holds its final value until the next accepted `start`.
- In IDLE, `a_out`=0 and `valid`=0.
- Asserting `reset_n` low at any point, including mid-run, immediately returns the block to reset values. No `done` pulse is produced.

## Timing
- `start` accepted at edge t: `valid`=1 from cycle t+1 with `a_out` = {`val_i(SEED)`}.
- For a full run, `valid` is high for exactly N = `num_cycles` cycles (t+1..t+N), and `done` pulses at t+N+1.
- `stop` high at cycle k in RUN: `valid` drops at k+1 and `done` pulses at k+1.
- With `num_cycles`==0: `done` pulses at t+1 and `valid` is never asserted.
- Minimum spacing between accepted starts is N+2 cycles (RUN + DONE + IDLE).
- All outputs are registered. There is no combinational path from input to output.
- `cycle_cnt` is 32 bits. `num_cycles` = 2^32-1 terminates normally with no wrap.

## Structure
- Package `trace_stim_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - `LFSR_MASK` = 32'h8020_0003;
  - functions `lfsr_step`, `val_i`, `reload_i`.
- Sub-module `stim_channel` (one per channel, generate loop) contains the 2-bit value register and 4-bit hold counter. Its inputs are `load_init`, `run`, the LFSR word, `hold_max` and a channel index parameter.
- The top level owns the FSM, LFSR, `cycle_cnt` and the latched configuration.

## Test plan
- Reset: assert `reset_n`=0 with random inputs → all outputs 0, FSM in IDLE. Release reset with no `start` → outputs stay 0 for 20 cycles.
- Basic run: `num_cycles`=3, `hold_max`=0, default SEED → `valid` high for exactly 3 cycles. First `a_out` = SEED[19:0] = 20'h1_2024. `a_out` in cycles 2 and 3 matches the reference model. `done` pulses at t+4. `cycle_cnt`=3 and holds.
- Hold: `num_cycles`=200, `hold_max`=15 → every channel value run length is in 1..16 samples and matches the reference model bit-exactly. With `hold_max`=0, every channel reloads on every sample.
- Abort: `num_cycles`=100, `stop` pulse at the 10th RUN cycle → exactly 10 valid samples, `done` the next cycle, `cycle_cnt`=10. A `start` during RUN is ignored.
- Zero length: `num_cycles`=0 → `done` at t+1, `valid` never high, `cycle_cnt`=0. A second `start` at t+3 runs normally.
- Reset mid-run: drop `reset_n` at sample 5 → immediately `valid`=0, `busy`=0, `cycle_cnt`=0, no `done`. Rerunning the same configuration reproduces the identical `a_out` sequence.

Source files
------------

// File: rtl/trace_stim_gen_pkg.sv
// ---------------------------------------------------------------------------
// trace_stim_pkg
//
// Shared definitions for the trace stimulus generator.
//
// Contents:
//   state_e    - controller states (IDLE, RUN, DONE)
//   LFSR_MASK  - feedback mask of the 32-bit Galois LFSR
//                (x^32 + x^22 + x^2 + x + 1, right-shifting form)
//   lfsr_step  - advance an LFSR word by one step
//   val_i      - 2-bit channel value drawn from an LFSR word
//   reload_i   - hold-counter reload value for a channel, capped by hold_max
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package trace_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Galois form: shift right, fold the mask in whenever a 1 falls out of bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        logic [31:0] nxt;
        nxt = l >> 1;
        if (l[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end
        return nxt;
    endfunction

    // Channel idx takes LFSR bits 2*idx and 2*idx+1. The 5-bit casts give the
    // wrap modulo 32 for free, so any channel index maps to a legal bit.
    function automatic logic [1:0] val_i(input logic [31:0] l, input int idx);
        logic [4:0] lo;
        logic [4:0] hi;
        lo = 5'(2 * idx);
        hi = 5'(2 * idx + 1);
        return {l[hi], l[lo]};
    endfunction

    // Four-bit window starting at bit 2*idx+20, wrapping round bit 31 to bit 0,
    // then clamped to the configured maximum hold.
    function automatic logic [3:0] reload_i(input logic [31:0] l, input int idx,
                                            input logic [3:0] hold_max);
        logic [3:0] r;
        r = {l[5'(2 * idx + 23)], l[5'(2 * idx + 22)],
             l[5'(2 * idx + 21)], l[5'(2 * idx + 20)]};
        return (r < hold_max) ? r : hold_max;
    endfunction

endpackage

// File: rtl/trace_stim_gen_if.sv
// ---------------------------------------------------------------------------
// trace_stim_gen_if
//
// Control / stimulus bundle of the trace stimulus generator.
//
// Signals:
//   start       - begin a run (acted on only while idle)
//   stop        - abort the current run (acted on only while running)
//   num_cycles  - trace length in samples, captured with start
//   hold_max    - maximum extra hold cycles per value, captured with start
//   a_out       - 2 bits per channel; channel i lives in a_out[2i+1:2i]
//   valid       - a_out is a trace sample this cycle
//   busy        - a run is in progress
//   done        - one-cycle pulse when a run ends
//   cycle_cnt   - samples emitted in the current or most recent run
//
// Modports:
//   master - the controller that launches runs and consumes the stimulus
//   slave  - the generator itself
// ---------------------------------------------------------------------------
interface trace_stim_gen_if #(
    parameter int N_CH = 10
) ();

    logic                start;
    logic                stop;
    logic [31:0]         num_cycles;
    logic [3:0]          hold_max;
    logic [2*N_CH-1:0]   a_out;
    logic                valid;
    logic                busy;
    logic                done;
    logic [31:0]         cycle_cnt;

    modport master (
        output start,
        output stop,
        output num_cycles,
        output hold_max,
        input  a_out,
        input  valid,
        input  busy,
        input  done,
        input  cycle_cnt
    );

    modport slave (
        input  start,
        input  stop,
        input  num_cycles,
        input  hold_max,
        output a_out,
        output valid,
        output busy,
        output done,
        output cycle_cnt
    );

endinterface

// File: rtl/trace_stim_gen_channel.sv
// ---------------------------------------------------------------------------
// stim_channel
//
// One 2-bit stimulus channel: a value register plus a hold counter. A value
// persists for (reload + 1) samples, after which a fresh value and reload
// are drawn from the shared LFSR word.
//
// Parameters:
//   IDX          - channel index, selects which LFSR bits feed this channel
//
// Ports:
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   load_init_i  - seed the channel from lfsr_i (start of a run)
//   run_i        - advance the channel by one sample
//   lfsr_i       - LFSR word the value and reload are drawn from
//   hold_max_i   - cap applied to the reload value
//   value_o      - current channel value (ungated; the top masks it)
// ---------------------------------------------------------------------------
module stim_channel
    import trace_stim_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_init_i,
    input  logic        run_i,
    input  logic [31:0] lfsr_i,
    input  logic [3:0]  hold_max_i,
    output logic [1:0]  value_o
);

    logic [1:0] value_q;
    logic [1:0] value_d;
    logic [3:0] hold_q;
    logic [3:0] hold_d;

    // A fresh draw happens at the start of a run and whenever the hold
    // counter has run out while running; otherwise the counter just ticks
    // down and the value is held.
    always_comb begin
        value_d = value_q;
        hold_d  = hold_q;
        if (load_init_i || (run_i && (hold_q == 4'd0))) begin
            value_d = val_i(lfsr_i, IDX);
            hold_d  = reload_i(lfsr_i, IDX, hold_max_i);
        end else if (run_i) begin
            hold_d = hold_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= 2'd0;
            hold_q  <= 4'd0;
        end else begin
            value_q <= value_d;
            hold_q  <= hold_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/trace_stim_gen.sv
// ---------------------------------------------------------------------------
// trace_stim_gen
//
// Deterministic pseudo-random stimulus source. Each of N_CH 2-bit channels
// gets LFSR-drawn values held for LFSR-drawn durations. A run emits a bounded
// number of samples marked by valid, can be aborted with stop, and always
// restarts from SEED so every run with the same configuration reproduces
// the same stimulus bit-exactly.
//
// Parameters:
//   N_CH  - number of 2-bit channels (1..16)
//   SEED  - LFSR seed; zero is replaced by one (an all-zero LFSR never moves)
//
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - trace_stim_gen_if slave: start/stop/num_cycles/hold_max in,
//              a_out/valid/busy/done/cycle_cnt out
// ---------------------------------------------------------------------------
module trace_stim_gen
    import trace_stim_pkg::*;
#(
    parameter int          N_CH = 10,
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic             clock,
    input  logic             reset_n,
    trace_stim_gen_if.slave  bus
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    state_e            state_q;
    state_e            state_d;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_d;
    logic [31:0]       num_q;
    logic [31:0]       num_d;
    logic [3:0]        hold_q;
    logic [3:0]        hold_d;
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;

    logic              load_init;
    logic              run;
    logic [31:0]       chan_word;
    logic [3:0]        chan_hold;
    logic [2*N_CH-1:0] chan_vals;

    // Next-state logic. A zero-length start goes straight to DONE so the
    // caller still sees a done pulse. The run ends after the sample whose
    // count equals num-1, i.e. exactly num samples, or after a stop cycle
    // whose own sample still counts.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        num_d     = num_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        load_init = 1'b0;
        run       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d = 32'd0;
                    if (bus.num_cycles == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        num_d     = bus.num_cycles;
                        hold_d    = bus.hold_max;
                        lfsr_d    = lfsr_step(SEED_EFF);
                        load_init = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                run    = 1'b1;
                cnt_d  = cnt_q + 32'd1;
                lfsr_d = lfsr_step(lfsr_q);
                if (bus.stop || (cnt_q == (num_q - 32'd1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channels draw from the seed itself when a run is launched and from the
    // running LFSR afterwards; the launch also uses the hold_max being
    // captured in that same cycle rather than the stale latched copy.
    always_comb begin
        chan_word = lfsr_q;
        chan_hold = hold_q;
        if (state_q != RUN) begin
            chan_word = SEED_EFF;
            chan_hold = bus.hold_max;
        end
    end

    // State, LFSR, latched configuration and sample counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            num_q   <= 32'd0;
            hold_q  <= 4'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            num_q   <= num_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        stim_channel #(
            .IDX(g)
        ) u_chan (
            .clock       (clock),
            .reset_n     (reset_n),
            .load_init_i (load_init),
            .run_i       (run),
            .lfsr_i      (chan_word),
            .hold_max_i  (chan_hold),
            .value_o     (chan_vals[2*g+1:2*g])
        );
    end

    // Outputs decode only registered state, so nothing reaches them from an
    // input combinationally. Channel registers keep stale values outside a
    // run, hence the masking of a_out.
    assign bus.valid     = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.a_out     = (state_q == RUN) ? chan_vals : '0;
    assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_trace_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_trace_stim_gen
//
// Self-checking bench for trace_stim_gen. An independent reference model
// fills a scoreboard with the expected a_out sequence when a run is launched;
// every valid sample pops and compares one entry.
// ---------------------------------------------------------------------------
module tb_trace_stim_gen;

    localparam int          TB_N_CH = 10;
    localparam int          AW      = 2 * TB_N_CH;
    localparam logic [31:0] TB_SEED = 32'hACE1_2024;

    logic clock = 1'b0;
    logic reset_n;

    int total = 0;
    int bad   = 0;

    logic [63:0] expQ[$];

    trace_stim_gen_if #(.N_CH(TB_N_CH)) bus ();

    trace_stim_gen #(
        .N_CH (TB_N_CH),
        .SEED (TB_SEED)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Move to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR: right shift, feedback x^32+x^22+x^2+x+1.
    function automatic logic [31:0] mStep(input logic [31:0] l);
        logic [31:0] n;
        n = {1'b0, l[31:1]};
        if (l[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Bit windows taken modulo 32 by rotating through a doubled word.
    function automatic logic [1:0] mVal(input logic [31:0] l, input int ch);
        logic [63:0] d;
        d = {l, l};
        return 2'(d >> ((2 * ch) % 32));
    endfunction

    function automatic logic [3:0] mHold(input logic [31:0] l, input int ch,
                                         input logic [3:0] hm);
        logic [63:0] d;
        logic [3:0]  r;
        d = {l, l};
        r = 4'(d >> ((2 * ch + 20) % 32));
        return (r > hm) ? hm : r;
    endfunction

    // Push the first 'count' expected a_out samples of a run.
    task automatic pushExpected(input logic [3:0] hm, input int count);
        logic [31:0] l;
        logic [1:0]  v[TB_N_CH];
        logic [3:0]  c[TB_N_CH];
        logic [63:0] w;
        l = TB_SEED;
        for (int ch = 0; ch < TB_N_CH; ch++) begin
            v[ch] = mVal(l, ch);
            c[ch] = mHold(l, ch, hm);
        end
        l = mStep(l);
        for (int s = 0; s < count; s++) begin
            if (s > 0) begin
                for (int ch = 0; ch < TB_N_CH; ch++) begin
                    if (c[ch] == 4'd0) begin
                        v[ch] = mVal(l, ch);
                        c[ch] = mHold(l, ch, hm);
                    end else begin
                        c[ch] = c[ch] - 4'd1;
                    end
                end
                l = mStep(l);
            end
            w = 64'd0;
            for (int ch = 0; ch < TB_N_CH; ch++) begin
                w = w | (64'(v[ch]) << (2 * ch));
            end
            expQ.push_back(w);
        end
    endtask

    // Launch a run and follow it to the idle cycle after done.
    // stopAt: RUN cycle (1-based) in which stop is raised, 0 for none.
    // startAt: RUN cycle in which a stray start is raised, 0 for none.
    task automatic applyStimulus(input logic [31:0] num, input logic [3:0] hm,
                                 input int stopAt, input int startAt,
                                 input logic stopWithStart, input string tag);
        int expN;
        int nValid;
        expN = ((stopAt > 0) && (stopAt < int'(num))) ? stopAt : int'(num);
        expQ.delete();
        pushExpected(hm, expN);

        bus.start      = 1'b1;
        bus.stop       = stopWithStart;
        bus.num_cycles = num;
        bus.hold_max   = hm;
        tick();
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.num_cycles = $urandom;
        bus.hold_max   = 4'($urandom);

        nValid = 0;
        for (int cyc = 1; cyc <= expN + 2; cyc++) begin
            if (bus.valid !== 1'b1) break;
            nValid++;
            if (expQ.size() == 0) begin
                checkOutput({tag, " extra sample"}, 64'(bus.a_out), 64'hDEAD);
                break;
            end
            if (cyc == 1) begin
                checkOutput({tag, " first sample"}, 64'(bus.a_out), 64'(TB_SEED[AW-1:0]));
            end
            checkOutput({tag, " a_out"}, 64'(bus.a_out), expQ.pop_front());
            checkOutput({tag, " running cnt"}, 64'(bus.cycle_cnt), 64'(cyc - 1));
            bus.stop  = (cyc == stopAt);
            bus.start = (cyc == startAt);
            tick();
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;

        checkOutput({tag, " valid count"}, 64'(nValid), 64'(expN));
        checkOutput({tag, " done/busy/valid"}, 64'({bus.done, bus.busy, bus.valid}), 64'h4);
        checkOutput({tag, " a_out in done"}, 64'(bus.a_out), 64'd0);
        checkOutput({tag, " final cnt"}, 64'(bus.cycle_cnt), 64'(expN));
        tick();
        checkOutput({tag, " idle outputs"},
                    64'({bus.done, bus.busy, bus.valid, bus.a_out}), 64'd0);
        checkOutput({tag, " cnt held"}, 64'(bus.cycle_cnt), 64'(expN));
    endtask

    initial begin
        // Reset with random inputs: everything stays at zero.
        reset_n        = 1'b0;
        bus.start      = 1'($urandom);
        bus.stop       = 1'($urandom);
        bus.num_cycles = $urandom;
        bus.hold_max   = 4'($urandom);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("in reset",
                        64'({bus.a_out, bus.valid, bus.busy, bus.done, bus.cycle_cnt}), 64'd0);
            bus.start = 1'($urandom);
            tick();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle after reset",
                        64'({bus.a_out, bus.valid, bus.busy, bus.done, bus.cycle_cnt}), 64'd0);
        end

        // Zero-length run: done one cycle later, no valid samples.
        bus.start      = 1'b1;
        bus.num_cycles = 32'd0;
        bus.hold_max   = 4'd3;
        tick();
        bus.start = 1'b0;
        checkOutput("zero done/busy/valid", 64'({bus.done, bus.busy, bus.valid}), 64'h4);
        checkOutput("zero cnt", 64'(bus.cycle_cnt), 64'd0);
        tick();
        checkOutput("zero idle", 64'({bus.done, bus.busy, bus.valid}), 64'd0);
        applyStimulus(32'd4, 4'd2, 0, 0, 1'b0, "after zero");

        // Basic run: three samples, no holding.
        applyStimulus(32'd3, 4'd0, 0, 0, 1'b0, "basic");

        // Long holds, with stop raised alongside start (start wins).
        applyStimulus(32'd200, 4'd15, 0, 0, 1'b1, "hold15");
        applyStimulus(32'd60, 4'd0, 0, 0, 1'b0, "hold0");

        // Abort at the tenth sample, with a stray start mid-run.
        applyStimulus(32'd100, 4'd5, 10, 4, 1'b0, "abort");

        // Reset in the middle of a run, then rerun the same configuration.
        expQ.delete();
        pushExpected(4'd7, 5);
        bus.start      = 1'b1;
        bus.num_cycles = 32'd50;
        bus.hold_max   = 4'd7;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            checkOutput("pre-reset a_out", 64'(bus.a_out), expQ.pop_front());
            if (cyc < 5) tick();
        end
        reset_n = 1'b0;
        #1;
        checkOutput("mid-run reset",
                    64'({bus.a_out, bus.valid, bus.busy, bus.done, bus.cycle_cnt}), 64'd0);
        tick();
        checkOutput("no done after reset", 64'(bus.done), 64'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("idle after mid reset", 64'({bus.done, bus.busy, bus.valid}), 64'd0);
        applyStimulus(32'd50, 4'd7, 0, 0, 1'b0, "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
